// File: rtl/alu_pkg.sv
// Shared operation encodings and datapath width for the RV32IM ALU.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_XOR    = 4'b0011;
    localparam logic [3:0] ALU_SLL    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] ALU_SRA    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_MUL    = 4'b1010;
    localparam logic [3:0] ALU_MULH   = 4'b1011;
    localparam logic [3:0] ALU_MULHSU = 4'b1100;
    localparam logic [3:0] ALU_MULHU  = 4'b1101;
    localparam logic [3:0] ALU_RSVD0  = 4'b1110;
    localparam logic [3:0] ALU_RSVD1  = 4'b1111;

endpackage

// File: rtl/alu_mul.sv
// Combinational multiplier. With ALU_MULH_EN a 33x33 signed array yields the
// full 64-bit product; otherwise only the low half is built (upper half is 0).
module alu_mul #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    input  logic              a_signed,
    input  logic              b_signed,
    output logic [2*XLEN-1:0] product
);

`ifdef ALU_MULH_EN
    logic signed [XLEN:0]     a_ext_s;
    logic signed [XLEN:0]     b_ext_s;
    logic signed [2*XLEN+1:0] full_s;

    // Extra top bit carries the sign only when that operand is treated as signed.
    assign a_ext_s = {a_signed & A[XLEN-1], A};
    assign b_ext_s = {b_signed & B[XLEN-1], B};
    assign full_s  = a_ext_s * b_ext_s;
    assign product = full_s[2*XLEN-1:0];
`else
    logic [XLEN-1:0] low_s;
    logic            unused_sign_s;

    assign unused_sign_s = a_signed ^ b_signed;
    assign low_s         = A * B;
    assign product       = {{XLEN{1'b0}}, low_s};
`endif

endmodule

// File: rtl/alu_rv32im.sv
// RV32IM ALU with one registered output stage. High-half multiply ops
// (MULH/MULHSU/MULHU) exist only when ALU_MULH_EN is defined.
module alu_rv32im #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALUControl,
    output logic            out_valid,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);
    import alu_pkg::*;

    logic [4:0]        shamt_s;
    logic              mul_a_signed_s;
    logic              mul_b_signed_s;
    logic [2*XLEN-1:0] mul_product_s;
    logic [XLEN-1:0]   result_s;
    logic              zero_s;
    logic [XLEN-1:0]   result_r;
    logic              zero_r;
    logic              valid_r;

    assign shamt_s = B[4:0];

    // Operand signedness for the shared multiplier.
    always_comb begin
        mul_a_signed_s = 1'b0;
        mul_b_signed_s = 1'b0;
        case (ALUControl)
            ALU_MULH: begin
                mul_a_signed_s = 1'b1;
                mul_b_signed_s = 1'b1;
            end
            ALU_MULHSU: begin
                mul_a_signed_s = 1'b1;
                mul_b_signed_s = 1'b0;
            end
            default: begin
                mul_a_signed_s = 1'b0;
                mul_b_signed_s = 1'b0;
            end
        endcase
    end

    alu_mul #(.XLEN(XLEN)) u_mul (
        .A        (A),
        .B        (B),
        .a_signed (mul_a_signed_s),
        .b_signed (mul_b_signed_s),
        .product  (mul_product_s)
    );

    // Operation select.
    always_comb begin
        result_s = {XLEN{1'b0}};
        case (ALUControl)
            ALU_AND:    result_s = A & B;
            ALU_OR:     result_s = A | B;
            ALU_ADD:    result_s = A + B;
            ALU_XOR:    result_s = A ^ B;
            ALU_SLL:    result_s = A << shamt_s;
            ALU_SLT:    result_s = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SUB:    result_s = A - B;
            ALU_SRL:    result_s = A >> shamt_s;
            ALU_SRA:    result_s = $unsigned($signed(A) >>> shamt_s);
            ALU_SLTU:   result_s = {{(XLEN-1){1'b0}}, (A < B)};
            ALU_MUL:    result_s = mul_product_s[XLEN-1:0];
`ifdef ALU_MULH_EN
            ALU_MULH:   result_s = mul_product_s[2*XLEN-1:XLEN];
            ALU_MULHSU: result_s = mul_product_s[2*XLEN-1:XLEN];
            ALU_MULHU:  result_s = mul_product_s[2*XLEN-1:XLEN];
`endif
            default:    result_s = {XLEN{1'b0}};
        endcase
    end

`ifndef ALU_MULH_EN
    logic unused_mul_hi_s;
    assign unused_mul_hi_s = ^mul_product_s[2*XLEN-1:XLEN];
`endif

    // Zero reflects the selected result of every op, reserved codes included.
    assign zero_s = (result_s == {XLEN{1'b0}});

    // Output stage: reset clears, valid input loads, idle cycles hold data.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {XLEN{1'b0}};
            zero_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else if (in_valid) begin
            result_r <= result_s;
            zero_r   <= zero_s;
            valid_r  <= 1'b1;
        end else begin
            result_r <= result_r;
            zero_r   <= zero_r;
            valid_r  <= 1'b0;
        end
    end

    assign Result    = result_r;
    assign Zero      = zero_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_alu_rv32im.sv
// Directed self-checking bench for alu_rv32im; expectations follow ALU_MULH_EN.
module tb_alu_rv32im;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic        out_valid;
    logic [31:0] Result;
    logic        Zero;

    int passed = 0;
    int total  = 0;

    alu_rv32im dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .Result     (Result),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input logic exp_v,
                             input logic [31:0] exp_r, input logic exp_z);
        check({tag, ".valid"},  {31'd0, out_valid}, {31'd0, exp_v});
        check({tag, ".result"}, Result, exp_r);
        check({tag, ".zero"},   {31'd0, Zero}, {31'd0, exp_z});
    endtask

    task automatic op(input string tag, input logic [3:0] code, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z);
        in_valid   = 1'b1;
        ALUControl = code;
        A          = a;
        B          = b;
        @(posedge clk);
        #1;
        check_out(tag, 1'b1, exp_r, exp_z);
    endtask

    task automatic idle(input string tag, input logic [31:0] exp_r, input logic exp_z);
        in_valid   = 1'b0;
        ALUControl = 4'b0010;
        A          = $urandom;
        B          = $urandom;
        @(posedge clk);
        #1;
        check_out(tag, 1'b0, exp_r, exp_z);
    endtask

    initial begin
        logic [31:0] mulh_exp;
        logic [31:0] mulhu_exp;
        logic [31:0] mulhsu_exp;
        logic        mulh_z;
        logic        mulhu_z;
        logic        mulhsu_z;
`ifdef ALU_MULH_EN
        mulh_exp   = 32'h00000000; mulh_z   = 1'b1;
        mulhu_exp  = 32'hFFFFFFFE; mulhu_z  = 1'b0;
        mulhsu_exp = 32'hFFFFFFFF; mulhsu_z = 1'b0;
`else
        mulh_exp   = 32'h00000000; mulh_z   = 1'b1;
        mulhu_exp  = 32'h00000000; mulhu_z  = 1'b1;
        mulhsu_exp = 32'h00000000; mulhsu_z = 1'b1;
`endif

        // Reset held two cycles with a nonzero op presented.
        rst        = 1'b1;
        in_valid   = 1'b1;
        ALUControl = 4'b0010;
        A          = 32'h00000005;
        B          = 32'h0000000A;
        @(posedge clk);
        #1;
        check_out("rst1", 1'b0, 32'h00000000, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst2", 1'b0, 32'h00000000, 1'b0);
        rst = 1'b0;

        op("add_first", 4'b0010, 32'h00000005, 32'h0000000A, 32'h0000000F, 1'b0);
        op("and",       4'b0000, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1);
        op("or",        4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
        op("xor",       4'b0011, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0);
        op("add_wrap",  4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);

        op("sub",       4'b0110, 32'h0000000A, 32'h00000005, 32'h00000005, 1'b0);
        op("sub_eq",    4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1);
        op("sub_wrap",  4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        op("slt_t",     4'b0101, 32'hFFFFFFFB, 32'h00000003, 32'h00000001, 1'b0);
        op("slt_f",     4'b0101, 32'h00000005, 32'hFFFFFFFD, 32'h00000000, 1'b1);
        op("sltu_f",    4'b1001, 32'hFFFFFFFB, 32'h00000003, 32'h00000000, 1'b1);
        op("sltu_t",    4'b1001, 32'h00000003, 32'hFFFFFFFB, 32'h00000001, 1'b0);

        op("sll",       4'b0100, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0);
        op("sll_mask",  4'b0100, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0);
        op("sra",       4'b1000, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
        op("srl",       4'b0111, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
        op("sra_pos",   4'b1000, 32'h40000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        op("srl_31",    4'b0111, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0);

        op("mul",       4'b1010, 32'h00000003, 32'h00000004, 32'h0000000C, 1'b0);
        op("mul_neg",   4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        op("mulh",      4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, mulh_exp,   mulh_z);
        op("mulhu",     4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, mulhu_exp,  mulhu_z);
        op("mulhsu",    4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, mulhsu_exp, mulhsu_z);

        // Hold after a nonzero result so a non-holding register is visible.
        op("add_hold",  4'b0010, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0);
        idle("hold_a1", 32'h12345678, 1'b0);
        idle("hold_a2", 32'h12345678, 1'b0);

        op("rsvd_e",    4'b1110, 32'h12345678, 32'h87654321, 32'h00000000, 1'b1);
        op("rsvd_f",    4'b1111, 32'h12345678, 32'h87654321, 32'h00000000, 1'b1);
        idle("hold_b1", 32'h00000000, 1'b1);
        idle("hold_b2", 32'h00000000, 1'b1);
        idle("hold_b3", 32'h00000000, 1'b1);

        // Reset in mid-stream overrides a valid op.
        op("pre_rst",   4'b0001, 32'h0000FF00, 32'h000000FF, 32'h0000FFFF, 1'b0);
        rst = 1'b1;
        op_during_rst();
        rst = 1'b0;
        op("post_rst",  4'b0011, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    task automatic op_during_rst();
        in_valid   = 1'b1;
        ALUControl = 4'b0010;
        A          = 32'h00000001;
        B          = 32'h00000001;
        @(posedge clk);
        #1;
        check_out("rst_mid", 1'b0, 32'h00000000, 1'b0);
    endtask

endmodule

// File: doc/alu_rv32im.md
Name: alu_rv32im

Overview:
- Integer ALU for the RV32IM datapath, covering the RV32I logic, arithmetic, shift and compare operations plus the RV32M multiply family.
- A 4-bit `ALUControl` code selects the operation applied to operands A and B.
- Result and Zero are registered, giving one-cycle latency with a valid strobe.
- Sits between the register-file/immediate operand muxes and the writeback/branch logic.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/control valid this cycle
- A  input  32  operand A (rs1)
- B  input  32  operand B (rs2 or immediate)
- ALUControl  input  4  operation select
- out_valid  output  1  Result/Zero valid
- Result  output  32  registered result
- Zero  output  1  registered flag, 1 when Result == 0

Behaviour:
- Single clock; reset is synchronous and active-high.
- rst high at a rising edge forces Result=0, Zero=0, out_valid=0. This overrides in_valid in the same cycle.
- Latency is exactly 1 cycle and throughput is 1 op per cycle, with no backpressure.
  - At an edge with in_valid=1: Result and Zero load the op result, and out_valid goes to 1.
  - At an edge with in_valid=0: out_valid goes to 0 and Result/Zero hold their previous values.
- Encodings:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SLT (signed)
  - 0110 SUB
  - 0111 SRL
  - 1000 SRA
  - 1001 SLTU
  - 1010 MUL (low 32 bits)
  - 1011 MULH (signed×signed, high 32)
  - 1100 MULHSU (signed A × unsigned B, high 32)
  - 1101 MULHU (unsigned×unsigned, high 32)
  - 1110 reserved
  - 1111 reserved
- Reserved codes: Result=0, Zero=1.
- ADD/SUB wrap modulo 2^32, with no overflow or carry outputs.
- Shifts use B[4:0] only; B[31:5] is ignored. SRA replicates A[31].
- SLT/SLTU produce 32'h00000001 when true and 32'h00000000 when false.
- Multiply products are computed at full 64 bits, then the selected half is output.
- Zero is computed from the 32-bit result value for every operation, not only SUB.
- Back-to-back ops with different codes each produce their own result on the following cycle; there is no interaction between consecutive ops.

Optional Feature:
- ALU_MULH_EN defined: codes 1011/1100/1101 behave as specified above, using a 33×33 signed multiplier.
- ALU_MULH_EN undefined: those three codes are treated as reserved (Result=0, Zero=1). Only the low-32 MUL is built.
- MUL (1010) is present in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit localparam constants for all 16 encodings (ALU_AND … ALU_MULHU, ALU_RSVD0/1)
  - XLEN
- One sub-module, alu_mul:
  - Inputs: A, B, a_signed, b_signed.
  - Output: 64-bit product.
  - Purely combinational and instantiated once.
- Top level holds the operation mux and the output register stage.

Test Plan:
- Reset: assert rst 2 cycles while in_valid=1 → Result=0, Zero=0, out_valid=0. Deassert rst → first op appears 1 cycle later.
- Logic/add: AND F0F0F0F0,0F0F0F0F → 00000000 Z=1; OR → FFFFFFFF Z=0; XOR AAAAAAAA,55555555 → FFFFFFFF; ADD 5,A → 0000000F. Each result appears 1 cycle after its input.
- Sub/compare: SUB A,5 → 00000005 Z=0; SUB 5,5 → 0 Z=1; SLT FFFFFFFB,3 → 1; SLT 5,FFFFFFFD → 0; SLTU FFFFFFFB,3 → 0.
- Shifts: SLL 1,4 → 00000010; SLL 1,0x24 → 00000010 (only B[4:0] used); SRA 80000000,4 → F8000000; SRL 80000000,4 → 08000000.
- Multiply: MUL 3,4 → 0000000C; MULH FFFFFFFF,FFFFFFFF → 00000000; MULHU FFFFFFFF,FFFFFFFF → FFFFFFFE; MULHSU FFFFFFFF,FFFFFFFF → FFFFFFFF.
  - Without ALU_MULH_EN, each of the three high-half ops → 0, Z=1.
- Reserved/hold: code 1111 with A=12345678, B=87654321 → Result=0, Z=1. Then in_valid=0 for 3 cycles → out_valid=0 and Result/Zero unchanged.
